// File: rtl/block_deinterleaver_pp_if.sv
// Handshake and data bundle for block_deinterleaver_pp.
// The master side drives the input stream, mode and serial back-pressure.
// The slave side is the deinterleaver itself.
interface block_deinterleaver_pp_if #(
    parameter int ROWS = 16,
    parameter int COLS = 8
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);

    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          mode;
    logic [CW-1:0] wr_index;
    logic [N-1:0]  par_out;
    logic          par_valid;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_ready;
    logic [15:0]   frame_count;

    modport master (
        output in_valid, in_bit, mode, ser_ready,
        input  in_ready, wr_index, par_out, par_valid, ser_out, ser_valid, frame_count
    );

    modport slave (
        input  in_valid, in_bit, mode, ser_ready,
        output in_ready, wr_index, par_out, par_valid, ser_out, ser_valid, frame_count
    );
endinterface

// File: rtl/block_deinterleaver_pp.sv
// Ping-pong row/column block (de)interleaver.
// Serial bits are scattered into one of two N-bit banks at their permuted
// position. A completed bank is published as a parallel word and drained
// serially in position order while the other bank fills.
module block_deinterleaver_pp #(
    parameter int ROWS = 16,
    parameter int COLS = 8
) (
    input logic                    clk,
    input logic                    reset,
    block_deinterleaver_pp_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] LAST      = CW'(N - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] ROWS_W    = CW'(ROWS);
    localparam logic [CW-1:0] COLS_W    = CW'(COLS);
    localparam logic [CW-1:0] ROWS_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] COLS_LAST = CW'(COLS - 1);

    logic [N-1:0]  bank [2];
    logic [1:0]    full;
    logic          fill;
    logic          drain;
    logic          mode_q;

    // Write position is tracked incrementally as p = minor*stride + major,
    // which avoids a divider on the n -> p mapping.
    logic [CW-1:0] wr_index;
    logic [CW-1:0] wr_minor;
    logic [CW-1:0] wr_major;
    logic [CW-1:0] wr_pos;
    logic [CW-1:0] rd_index;

    logic          done_q;
    logic          done_bank;
    logic [N-1:0]  par_out;
    logic          par_valid;
    logic [15:0]   frame_count;

    logic          wr_fire;
    logic          rd_fire;
    logic          wr_last;
    logic          rd_last;
    logic          eff_mode;
    logic [CW-1:0] stride;
    logic [CW-1:0] minor_last;
    logic [1:0]    set_full;
    logic [1:0]    clr_full;

    assign wr_fire  = bus.in_valid & bus.in_ready;
    assign rd_fire  = bus.ser_valid & bus.ser_ready;
    assign wr_last  = (wr_index == LAST);
    assign rd_last  = (rd_index == LAST);

    // The first bit of a frame uses the live mode; later bits use the latched copy.
    assign eff_mode   = (wr_index == '0) ? bus.mode : mode_q;
    assign stride     = eff_mode ? ROWS_W : COLS_W;
    assign minor_last = eff_mode ? COLS_LAST : ROWS_LAST;

    // A write completes the fill bank and a read completes the drain bank;
    // both can happen in one cycle because they always target different banks.
    assign set_full = (wr_fire && wr_last) ? (2'b01 << fill)  : 2'b00;
    assign clr_full = (rd_fire && rd_last) ? (2'b01 << drain) : 2'b00;

    // Write-side counters, mode latch and frame counter.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (reset) begin
            wr_index    <= '0;
            wr_minor    <= '0;
            wr_major    <= '0;
            wr_pos      <= '0;
            fill        <= 1'b0;
            mode_q      <= 1'b0;
            frame_count <= '0;
        end else if (wr_fire) begin
            if (wr_index == '0) begin
                mode_q <= bus.mode;
            end
            if (wr_last) begin
                wr_index    <= '0;
                wr_minor    <= '0;
                wr_major    <= '0;
                wr_pos      <= '0;
                fill        <= ~fill;
                frame_count <= frame_count + 16'd1;
            end else if (wr_minor == minor_last) begin
                wr_index <= wr_index + ONE;
                wr_minor <= '0;
                wr_major <= wr_major + ONE;
                wr_pos   <= wr_major + ONE;
            end else begin
                wr_index <= wr_index + ONE;
                wr_minor <= wr_minor + ONE;
                wr_pos   <= wr_pos + stride;
            end
        end
    end

    // Bank storage: scatter each accepted bit to its permuted position.
    always_ff @(posedge clk) begin
        // NOTE: bank contents are deliberately not reset; the full flags
        // decide what is valid, so stale data is never observed.
        if (wr_fire) begin
            bank[fill][wr_pos] <= bus.in_bit;
        end
    end

    // Read-side index and drain pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_index <= '0;
            drain    <= 1'b0;
        end else if (rd_fire) begin
            if (rd_last) begin
                rd_index <= '0;
                drain    <= ~drain;
            end else begin
                rd_index <= rd_index + ONE;
            end
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_full) & ~clr_full;
        end
    end

    // Parallel output: load the completed bank one cycle after its last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            done_bank <= 1'b0;
            par_out   <= '0;
            par_valid <= 1'b0;
        end else begin
            done_q    <= wr_fire & wr_last;
            done_bank <= fill;
            par_valid <= done_q;
            if (done_q) begin
                par_out <= bank[done_bank];
            end
        end
    end

    assign bus.in_ready    = !reset && !full[fill];
    assign bus.ser_valid   = full[drain];
    assign bus.ser_out     = bank[drain][rd_index];
    assign bus.wr_index    = wr_index;
    assign bus.par_out     = par_out;
    assign bus.par_valid   = par_valid;
    assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_block_deinterleaver_pp.sv
// Directed bench for block_deinterleaver_pp: a 16x8 instance for the main
// behaviour and a 5x3 instance for the non-power-of-two frame length.
module tb_block_deinterleaver_pp;
    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    block_deinterleaver_pp_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    block_deinterleaver_pp_if #(.ROWS(5), .COLS(3)) bus5 ();

    block_deinterleaver_pp #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    block_deinterleaver_pp #(.ROWS(5), .COLS(3)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Edge monitors on the 16x8 instance.
    logic ser_q [$];
    int   par_cyc [$];
    int   cyc         = 0;
    int   ready_drops = 0;
    int   ser_gaps    = 0;
    logic track_gap   = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.ser_valid && bus.ser_ready) ser_q.push_back(bus.ser_out);
        if (bus.par_valid) par_cyc.push_back(cyc);
        if (!reset && bus.in_valid && !bus.in_ready) ready_drops <= ready_drops + 1;
        if (track_gap && !bus.ser_valid) ser_gaps <= ser_gaps + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference permutation straight from the index formulas.
    function automatic logic [127:0] permute(input logic [127:0] d, input logic m);
        logic [127:0] r;
        int p;
        r = '0;
        for (int n = 0; n < N; n++) begin
            p = m ? (n % COLS) * ROWS + n / COLS : (n % ROWS) * COLS + n / ROWS;
            r[p] = d[n];
        end
        return r;
    endfunction

    function automatic logic [127:0] beats(input int start);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (start + i < ser_q.size()) r[i] = ser_q[start + i];
        end
        return r;
    endfunction

    // Offer nbits of d; mode switches from m0 to m1 at bit sw_at. Leaves in_valid high.
    task automatic send_frame(input logic [127:0] d, input logic m0, input int sw_at,
                              input logic m1, input int nbits);
        int g;
        for (int n = 0; n < nbits; n++) begin
            bus.mode     = (n >= sw_at) ? m1 : m0;
            bus.in_bit   = d[n];
            bus.in_valid = 1'b1;
            g = 0;
            while (!bus.in_ready && g < 2000) begin
                tick();
                g++;
            end
            if (g >= 2000) begin
                check("in_ready_timeout", bus.in_ready, 1'b1);
                return;
            end
            tick();
        end
    endtask

    task automatic wait_drain(input string tag);
        int g;
        g = 0;
        while (bus.ser_valid && g < 2000) begin
            tick();
            g++;
        end
        check(tag, bus.ser_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic [127:0] f_a;
    logic [127:0] f_b;
    logic [127:0] f_g;
    logic [127:0] p1;
    int           s;
    int           pc;
    int           rd0;
    int           gp0;

    initial begin
        f_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        f_b = ~f_a;
        f_g = {f_a[63:0], f_a[127:64]};

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.mode       = 1'b0;
        bus.ser_ready  = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.in_bit    = 1'b0;
        bus5.mode      = 1'b0;
        bus5.ser_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_ser_valid", bus.ser_valid, 1'b0);
        check("rst_par_valid", bus.par_valid, 1'b0);
        check("rst_par_out", bus.par_out, '0);
        check("rst_frame_count", bus.frame_count, 16'd0);
        check("rst_wr_index", bus.wr_index, 7'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1'b1);

        // 1: mode 0, only n=1 set -> position 8
        s  = ser_q.size();
        pc = par_cyc.size();
        send_frame(128'h2, 1'b0, N, 1'b0, N);
        bus.in_valid = 1'b0;
        check("t1_frame_count", bus.frame_count, 16'd1);
        check("t1_wr_wrap", bus.wr_index, 7'd0);
        check("t1_par_valid_early", bus.par_valid, 1'b0);
        tick();
        check("t1_par_valid", bus.par_valid, 1'b1);
        check("t1_par_out", bus.par_out, 128'h100);
        check("t1_ser_valid", bus.ser_valid, 1'b1);
        tick();
        check("t1_par_pulse_end", bus.par_valid, 1'b0);
        wait_drain("t1_drain");
        check("t1_serial", beats(s), 128'h100);
        check("t1_par_pulses", par_cyc.size() - pc, 1);
        check("t1_par_hold", bus.par_out, 128'h100);

        // 2: mode 1, only n=1 set -> position 16; then interleave/deinterleave round trip
        send_frame(128'h2, 1'b1, N, 1'b1, N);
        bus.in_valid = 1'b0;
        tick();
        check("t2_par_out", bus.par_out, 128'h1_0000);
        wait_drain("t2_drain_a");
        send_frame(f_a, 1'b1, N, 1'b1, N);
        bus.in_valid = 1'b0;
        tick();
        p1 = bus.par_out;
        check("t2_interleaved", p1, permute(f_a, 1'b1));
        wait_drain("t2_drain_b");
        s = ser_q.size();
        send_frame(p1, 1'b0, N, 1'b0, N);
        bus.in_valid = 1'b0;
        tick();
        check("t2_round_trip", bus.par_out, f_a);
        wait_drain("t2_drain_c");
        check("t2_round_trip_serial", beats(s), f_a);

        // 3: four back-to-back frames at full rate
        do_reset();
        s   = ser_q.size();
        pc  = par_cyc.size();
        rd0 = ready_drops;
        gp0 = ser_gaps;
        send_frame(f_a, 1'b0, N, 1'b0, N);
        check("t3_ser_valid_first", bus.ser_valid, 1'b1);
        track_gap = 1'b1;
        send_frame(f_b, 1'b0, N, 1'b0, N);
        send_frame(f_a, 1'b0, N, 1'b0, N);
        send_frame(f_b, 1'b0, N, 1'b0, N);
        track_gap    = 1'b0;
        bus.in_valid = 1'b0;
        check("t3_no_ready_drop", ready_drops - rd0, 0);
        check("t3_no_ser_gap", ser_gaps - gp0, 0);
        check("t3_frame_count", bus.frame_count, 16'd4);
        tick();
        tick();
        check("t3_par_pulses", par_cyc.size() - pc, 4);
        for (int i = 1; i < 4; i++) begin
            if (pc + i < par_cyc.size())
                check("t3_par_spacing", par_cyc[pc + i] - par_cyc[pc + i - 1], 128);
        end
        wait_drain("t3_drain");
        check("t3_serial_f2", beats(s + 128), permute(f_b, 1'b0));
        check("t3_serial_f4", beats(s + 384), permute(f_b, 1'b0));

        // 4: back-pressure fills both banks, then drain releases one
        do_reset();
        bus.ser_ready = 1'b0;
        s   = ser_q.size();
        rd0 = ready_drops;
        send_frame(f_a, 1'b0, N, 1'b0, N);
        send_frame(f_b, 1'b0, N, 1'b0, N);
        check("t4_ready_held", ready_drops - rd0, 0);
        check("t4_in_ready_low", bus.in_ready, 1'b0);
        check("t4_frame_count", bus.frame_count, 16'd2);
        tick();
        check("t4_ready_stays_low", bus.in_ready, 1'b0);
        bus.in_valid  = 1'b0;
        bus.ser_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            if (i == N - 2) check("t4_ready_before_last", bus.in_ready, 1'b0);
            if (i == N - 1) check("t4_ready_after_last", bus.in_ready, 1'b1);
        end
        check("t4_serial_a", beats(s), permute(f_a, 1'b0));
        wait_drain("t4_drain");
        check("t4_serial_b", beats(s + 128), permute(f_b, 1'b0));

        // 5: mode change mid-frame only affects the next frame
        do_reset();
        s = ser_q.size();
        send_frame(f_a, 1'b0, 50, 1'b1, N);
        bus.in_valid = 1'b0;
        tick();
        check("t5_frame0_mode0", bus.par_out, permute(f_a, 1'b0));
        send_frame(f_a, 1'b1, N, 1'b1, N);
        bus.in_valid = 1'b0;
        tick();
        check("t5_frame1_mode1", bus.par_out, permute(f_a, 1'b1));
        wait_drain("t5_drain");
        check("t5_serial_frame0", beats(s), permute(f_a, 1'b0));

        // 6: reset in the middle of frame 2 while frame 1 drains
        do_reset();
        bus.mode = 1'b0;
        send_frame(f_a, 1'b0, N, 1'b0, N);
        send_frame(f_b, 1'b0, N, 1'b0, N);
        send_frame(f_a, 1'b0, N, 1'b0, 70);
        check("t6_draining", bus.ser_valid, 1'b1);
        check("t6_mid_frame", bus.wr_index, 7'd70);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("t6_in_ready_in_reset", bus.in_ready, 1'b0);
        tick();
        check("t6_frame_count", bus.frame_count, 16'd0);
        check("t6_par_out", bus.par_out, '0);
        check("t6_par_valid", bus.par_valid, 1'b0);
        check("t6_ser_valid", bus.ser_valid, 1'b0);
        check("t6_wr_index", bus.wr_index, 7'd0);
        reset = 1'b0;
        #1;
        check("t6_in_ready_after", bus.in_ready, 1'b1);
        s = ser_q.size();
        send_frame(f_g, 1'b0, N, 1'b0, N);
        bus.in_valid = 1'b0;
        tick();
        check("t6_par_out_after", bus.par_out, permute(f_g, 1'b0));
        check("t6_frame_count_after", bus.frame_count, 16'd1);
        wait_drain("t6_drain");
        check("t6_serial_after", beats(s), permute(f_g, 1'b0));

        // 7: 5x3 instance, N = 15
        check("t7_idle_ready", bus5.in_ready, 1'b1);
        for (int n = 0; n < 15; n++) begin
            bus5.in_bit   = (n == 7);
            bus5.mode     = 1'b0;
            bus5.in_valid = 1'b1;
            if (n == 14) check("t7_wr_index_14", bus5.wr_index, 4'd14);
            tick();
        end
        check("t7_wr_wrap", bus5.wr_index, 4'd0);
        check("t7_frame_count", bus5.frame_count, 16'd1);
        bus5.in_valid = 1'b0;
        tick();
        check("t7_par_out_mode0", bus5.par_out, 15'h0080);
        for (int n = 0; n < 15; n++) begin
            bus5.in_bit   = (n == 3);
            bus5.mode     = 1'b1;
            bus5.in_valid = 1'b1;
            tick();
        end
        bus5.in_valid = 1'b0;
        tick();
        check("t7_par_out_mode1", bus5.par_out, 15'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
